// File: rtl/port_arbiter.sv
// port_arbiter: round-robin arbiter sharing one switch output link among PORTS_NUM+1 requesters.
// Define ARB_TIMEOUT_EN to add the SEND watchdog (TIMEOUT_CYCLES) and the sticky err_o flag.
module port_arbiter #(
    parameter int PORTS_NUM = 4,
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 64,
`endif
    localparam int N        = PORTS_NUM + 1,
    localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1
) (
    input  logic                  clk,
    input  logic                  a_rst_n,
    input  logic [N-1:0]          req_i,
    input  logic [BUS_SIZE*N-1:0] data_i,
    output logic [N-1:0]          ack_o,
    output logic [N-1:0]          grant_o,
    output logic [BUS_SIZE-1:0]   data_o,
    output logic                  wr_ready_o,
    input  logic                  r_ready_i,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick;
    logic          found;
    logic [N-1:0]  req_q;
    logic          r_ready_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] send_cnt;
`else
    assign err_o = 1'b0;
`endif

    // NOTE: '===' makes an X or Z (unconnected) line read as "no request" in simulation.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_q[i] = (req_i[i] === 1'b1);
        end
        r_ready_q = (r_ready_i === 1'b1);
    end

    // First qualified requester found scanning circularly from rr_ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_q[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign busy_o = (state != IDLE);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            ack_o      <= '0;
            grant_o    <= '0;
            data_o     <= '0;
            wr_ready_o <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            send_cnt   <= '0;
            err_o      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner         <= pick;
                        grant_o       <= '0;
                        grant_o[pick] <= 1'b1;
                        data_o        <= data_i[int'(pick)*BUS_SIZE +: BUS_SIZE];
                        wr_ready_o    <= 1'b1;
                        state         <= SEND;
`ifdef ARB_TIMEOUT_EN
                        send_cnt      <= '0;
`endif
                    end
                end
                SEND: begin
                    if (r_ready_q) begin
                        wr_ready_o <= 1'b0;
                        ack_o      <= grant_o;
                        state      <= ACK;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (send_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // Give up on the link: drop the flit but still release the requester.
                        wr_ready_o <= 1'b0;
                        ack_o      <= grant_o;
                        err_o      <= 1'b1;
                        state      <= ACK;
                    end else begin
                        send_cnt <= send_cnt + 1'b1;
                    end
`endif
                end
                ACK: begin
                    // A read strobe still high here is stale and must not end the handshake.
                    if (((req_q & grant_o) == '0) && !r_ready_q) begin
                        ack_o   <= '0;
                        grant_o <= '0;
                        rr_ptr  <= (owner == PW'(PORTS_NUM)) ? '0 : owner + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ack_o      <= '0;
                    grant_o    <= '0;
                    data_o     <= '0;
                    wr_ready_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/port_arbiter.md
Name: port_arbiter

Overview:
Round-robin arbiter that shares one switch output link among the PORTS_NUM+1 per-queue transceivers of a switch, including the local port.
- Each requester raises its ready line for this output.
- The arbiter grants one requester, latches its flit, and drives the downstream wr_ready/r_ready handshake.
- It then acknowledges the requester and rotates priority.
- One instance sits on each switch output, between the transceivers' data_o/wr_ready_out slices and the link.

Parameters:
PORTS_NUM, 4, number of network ports; requester count N = PORTS_NUM+1.
DATA_SIZE, 32, flit payload width.
ADDR_SIZE, 4, flit address width.
BUS_SIZE, DATA_SIZE+ADDR_SIZE+1, localparam, flit bus width.
TIMEOUT_CYCLES, 64, SEND watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
clk  input  1  system clock; one clock domain, all logic on the rising edge.
a_rst_n  input  1  reset, asynchronous, active-low.
req_i  input  N  per-requester request; a requester holds its flit stable while its request is high.
data_i  input  BUS_SIZE*N  requester flits; slice i is [i*BUS_SIZE +: BUS_SIZE].
ack_o  output  N  per-requester "flit consumed" level, returned to the transceiver's r_ready_in.
grant_o  output  N  one-hot current owner; all zeros when idle.
data_o  output  BUS_SIZE  latched flit towards the link.
wr_ready_o  output  1  flit valid on the link.
r_ready_i  input  1  downstream has read the flit.
busy_o  output  1  high in any state other than IDLE.
err_o  output  1  sticky timeout flag; tied to 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (a_rst_n=0, asynchronous, honoured mid-transfer):
  - state=IDLE, rr_ptr=0;
  - ack_o=0, grant_o=0, data_o=0, wr_ready_o=0, busy_o=0, err_o=0;
  - any in-flight flit is dropped.
- Request qualification: a request bit counts only when it is === 1'b1. X or Z (unconnected port) counts as no request.
- rr_ptr: width $clog2(N), range 0..PORTS_NUM.
- IDLE:
  - If any qualified request, select the first qualified index g scanning circularly from rr_ptr.
  - At that edge: grant_o[g]<=1, data_o<=data_i slice g, wr_ready_o<=1, go to SEND.
  - Latency: request sampled at edge k gives wr_ready_o/data_o high after edge k.
- SEND:
  - Hold data_o and wr_ready_o.
  - When r_ready_i===1 is sampled: wr_ready_o<=0, ack_o[g]<=1, go to ACK.
  - r_ready_i is not sampled on the IDLE->SEND edge; the earliest completion is 1 cycle after wr_ready_o rises.
  - req_i[g] dropping during SEND is ignored; the latched flit is still delivered.
- ACK:
  - Wait until req_i[g] is not high AND r_ready_i is low (this rejects a stale read strobe).
  - Then: ack_o[g]<=0, grant_o<=0, rr_ptr<=(g==PORTS_NUM)?0:g+1, go to IDLE.
  - Minimum ACK duration is 1 cycle.
- Throughput: at best one flit per 3 cycles (IDLE, SEND, ACK).
- Fairness: a continuously requesting port waits at most N-1 grants.
- Simultaneous requests: the lowest index at or after rr_ptr wins, wrapping PORTS_NUM->0.
- Only one ack_o bit and one grant_o bit are ever high. ack_o is never high together with wr_ready_o.
- Unreachable state encodings go to IDLE with all outputs cleared.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to SEND and increments each cycle in SEND.
  - On reaching TIMEOUT_CYCLES without r_ready_i: wr_ready_o<=0, err_o<=1 (sticky until reset), ack_o[g]<=1, go to ACK. The flit is discarded and the requester is released.
- Undefined: no counter; SEND waits indefinitely; err_o is constant 0.

Test Plan:
- Reset then single request: PORTS_NUM=4, req_i=5'b00100, data_i slice 2 = 37'h1_2345_6789. Required: grant_o=00100, data_o=slice 2, wr_ready_o=1 one cycle later. r_ready_i pulse gives ack_o[2]=1 and wr_ready_o=0. Dropping req_i[2] returns to IDLE with rr_ptr=3.
- Contention rotation: req_i=5'b11111 held, with each ack answered by a 1-cycle request drop and re-raise. Required: grant order 0,1,2,3,4,0; no index is granted twice before every other index is granted once.
- Wrap and skip: rr_ptr=4 with req_i=5'b00011. Required: grant 0, then 1; indices 2..4 never granted. Bits driven Z are never granted.
- Stale r_ready and withdrawal: r_ready_i held high through ACK, so IDLE is not re-entered until it drops. Separately, req_i[g] dropped mid-SEND: the flit is still presented and completes normally.
- Reset mid-transfer: a_rst_n low in SEND with wr_ready_o=1. Required: wr_ready_o, grant_o and ack_o go to 0 without waiting for a clock edge; after release, the next request is granted from rr_ptr=0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, r_ready_i held low: wr_ready_o falls 8 cycles after entering SEND, err_o=1, ack_o[g]=1. err_o stays high across later successful transfers until reset.
